seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed 4-digit seven-segment display driver downstream of the segment-encoder stage, which produces 7-bit segment patterns. Patterns are written into a shadow buffer and committed as a whole at a frame boundary, so the display never shows a mix of old and new values. A prescaler steps through the digits and drives active-low anode and segment lines for a common-anode display.

## Interface
- DIV, default 50000: clock cycles each digit is lit; legal range ≥ 2.
- BLANK_CYC, default 4: all-anodes-off cycles between digits; used only when blanking is compiled in (see Configuration); legal range ≥ 1.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write wr_seg into shadow slot wr_idx.
- wr_idx  in  2  target digit, 0 = rightmost.
- wr_seg  in  7  segment pattern {g,f,e,d,c,b,a}, 1 = segment lit.
- wr_commit  in  1  request shadow→active copy at the next frame boundary.
- wr_ready  out  1  high when writes and commits are accepted.
- seg_n  out  7  segment drive, active-low.
- an_n  out  4  anode drive, one-hot active-low.
- frame_tick  out  1  one-cycle pulse when the digit index wraps 3→0.

## Operation
- Storage: shadow[0..3] and active[0..3], 7 bits each; all reset to 7'h00.
- Write: a write is accepted when wr_en=1 and wr_ready=1 at a clock edge; shadow[wr_idx] takes wr_seg. Writes while wr_ready=0 are dropped; the shadow buffer is unchanged.
- Commit: a commit is accepted when wr_commit=1 and wr_ready=1. It sets pending=1, which drives wr_ready=0.
- Same-cycle write and commit: the write lands in the shadow buffer and is part of that commit.
- Frame boundary: the edge where the digit index goes 3→0.
  - If pending=1 at that edge, active takes shadow, pending clears, and wr_ready returns to 1 the next cycle.
  - The new digit 0 shows the committed data.
- A commit accepted in the boundary cycle itself is not applied at that boundary; it applies at the following one.
- FSM states:
  - SCAN: the selected digit is lit. cnt counts 0..DIV-1; at DIV-1 go to BLANK (macro defined) or advance the digit and stay in SCAN.
  - BLANK: an_n=4'b1111, seg_n=7'h7F. bcnt counts 0..BLANK_CYC-1, then advance the digit and return to SCAN.
- Digit index is 2 bits and wraps 3→0 naturally.
- In SCAN, an_n = ~(4'b0001 << digit) and seg_n = ~active[digit].
- All outputs are registered.

## Timing
- Reset values: an_n=4'b1110, seg_n=7'h7F, frame_tick=0, wr_ready=1, pending=0, FSM=SCAN, digit=0, cnt=0.
- Reset asserted mid-frame or with a commit pending: everything returns to reset values immediately; the pending commit is lost and both buffers clear.
- Frame length: 4·DIV cycles, or 4·(DIV+BLANK_CYC) with blanking.
- frame_tick is high for exactly the one cycle in which digit 0 first shows (the same cycle the committed data appears).
- Commit latency: from acceptance to display, between 1 and one frame + 1 cycles. wr_ready stays low for the whole interval.
- Outputs change only at state or digit transitions; no glitches between transitions.

## Configuration
- SEG7_SCAN_BLANK_EN defined: the BLANK state is present. Each digit is followed by BLANK_CYC cycles with all anodes off, to suppress ghosting.
- SEG7_SCAN_BLANK_EN undefined: no BLANK state; the digit advances directly after DIV cycles and BLANK_CYC is ignored.

## Test plan
- Reset release, DIV=4, no blanking:
  - an_n shows 1110, 1101, 1011, 0111, each for 4 cycles, then 1110 again.
  - seg_n=7F throughout.
  - frame_tick pulses every 16 cycles.
- Write shadow[2]=7'h5B, then commit mid-frame:
  - wr_ready drops the cycle after commit.
  - Digit 2 still shows 7F until after the next frame_tick; then the an_n=1011 phase shows seg_n=7'h24.
  - wr_ready rises at the boundary.
- Write 7'h06 to idx 1 while wr_ready=0 -> dropped. A second commit after wr_ready returns leaves digit 1 unchanged.
- Same cycle: wr_en (idx 0, 7'h3F) and wr_commit -> after the next boundary, digit 0 shows seg_n=7'h40.
- SEG7_SCAN_BLANK_EN, DIV=4, BLANK_CYC=2 -> each digit is lit for 4 cycles followed by 2 cycles of an_n=1111 and seg_n=7F; frame length 24.
- Assert rst_n low with a commit pending mid-scan:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, display is blank and wr_ready=1.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit time-multiplexed common-anode seven-segment driver with frame-synchronous commit.
// Define SEG7_SCAN_BLANK_EN to insert BLANK_CYC all-off cycles after each digit (anti-ghosting).
module seg7_scan #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_idx,
    input  logic [6:0] wr_seg,
    input  logic       wr_commit,
    output logic       wr_ready,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       frame_tick
);

    // state | meaning
    // SCAN  | selected digit lit, cnt counts 0..DIV-1
    // BLANK | all anodes off, bcnt counts 0..BLANK_CYC-1
    localparam logic [0:0] ST_SCAN  = 1'b0;
    localparam logic [0:0] ST_BLANK = 1'b1;

`ifdef SEG7_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BLANK_CYC - 1);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [1:0]        digit_q, digit_d;
    logic              pending_q, pending_d;
    logic [6:0]        shadow_q [4];
    logic [6:0]        shadow_d [4];
    logic [6:0]        active_q [4];
    logic [6:0]        active_d [4];
    logic [3:0]        an_n_q, an_n_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic              frame_tick_q, frame_tick_d;

    logic wr_acc;
    logic commit_acc;
    logic advance;
    logic boundary;

    assign wr_ready   = ~pending_q;
    assign wr_acc     = wr_en & ~pending_q;
    assign commit_acc = wr_commit & ~pending_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        advance = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (BLANK_EN) begin
                        state_d = ST_BLANK;
                        bcnt_d  = '0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BLANK: begin
                if (bcnt_q == BCNT_MAX) begin
                    bcnt_d  = '0;
                    state_d = ST_SCAN;
                    advance = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
                bcnt_d  = '0;
            end
        endcase
        digit_d  = advance ? digit_q + 2'd1 : digit_q;
        boundary = advance && (digit_q == 2'd3);
    end

    // A commit accepted in the boundary cycle itself waits for the next boundary.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (wr_acc) begin
            shadow_d[wr_idx] = wr_seg;
        end
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (commit_acc) begin
            pending_d = 1'b1;
        end
    end

    // Outputs are computed from next-state so they register in step with the FSM.
    always_comb begin
        frame_tick_d = boundary;
        if (state_d == ST_BLANK) begin
            an_n_d  = 4'hF;
            seg_n_d = 7'h7F;
        end else begin
            an_n_d  = ~(4'b0001 << digit_d);
            seg_n_d = ~active_d[digit_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SCAN;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            digit_q      <= 2'd0;
            pending_q    <= 1'b0;
            an_n_q       <= 4'b1110;
            seg_n_q      <= 7'h7F;
            frame_tick_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 7'h00;
                active_q[i] <= 7'h00;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            digit_q      <= digit_d;
            pending_q    <= pending_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            frame_tick_q <= frame_tick_d;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: time-indexed reference model plus directed literal checks.
// Honours SEG7_SCAN_BLANK_EN if the build defines it.
module tb_seg7_scan;
    localparam int DIV       = 4;
    localparam int BLANK_CYC = 2;
`ifdef SEG7_SCAN_BLANK_EN
    localparam int PER       = DIV + BLANK_CYC;
    localparam int FRAME_LIT = 24;
`else
    localparam int PER       = DIV;
    localparam int FRAME_LIT = 16;
`endif
    localparam int FRAME = 4 * PER;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [6:0] wr_seg;
    logic       wr_commit;
    logic       wr_ready;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       frame_tick;

    seg7_scan #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_seg(wr_seg),
        .wr_commit(wr_commit), .wr_ready(wr_ready), .seg_n(seg_n), .an_n(an_n),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: cycles since reset release, shadow/active arrays and a pending flag.
    int         t;
    logic [6:0] m_sh  [4];
    logic [6:0] m_act [4];
    bit         m_pend;
    bit         m_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t      = 0;
            m_pend = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_sh[i]  = 7'h00;
                m_act[i] = 7'h00;
            end
        end else begin
            m_rdy = !m_pend;
            t     = t + 1;
            if ((t % FRAME) == 0 && m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
            if (wr_en && m_rdy) m_sh[wr_idx] = wr_seg;
            if (wr_commit && m_rdy) m_pend = 1'b1;
        end
    end

    function automatic logic [3:0] exp_an();
        int pos = t % FRAME;
        int d   = pos / PER;
        int ph  = pos % PER;
        logic [3:0] oh = 4'b0001 << d;
        return (ph < DIV) ? ~oh : 4'hF;
    endfunction

    function automatic logic [6:0] exp_seg();
        int pos = t % FRAME;
        int d   = pos / PER;
        int ph  = pos % PER;
        return (ph < DIV) ? ~m_act[d] : 7'h7F;
    endfunction

    function automatic logic exp_tick();
        return (t > 0) && ((t % FRAME) == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("model_an_n", 32'(an_n), 32'(exp_an()));
            chk("model_seg_n", 32'(seg_n), 32'(exp_seg()));
            chk("model_frame_tick", 32'(frame_tick), 32'(exp_tick()));
            chk("model_wr_ready", 32'(wr_ready), 32'(!m_pend));
        end
    end

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (frame_tick !== 1'b1 && cyc < 200);
        if (frame_tick !== 1'b1) chk("wait_tick_timeout", 32'(frame_tick), 32'd1);
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an_n !== pat && n < 200);
        if (an_n !== pat) chk("wait_an_timeout", 32'(an_n), 32'(pat));
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        wr_idx    = 2'd0;
        wr_seg    = 7'h00;
        wr_commit = 1'b0;
    endtask

    initial begin
        int cyc;
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_an_n", 32'(an_n), 32'h0E);
        chk("reset_seg_n", 32'(seg_n), 32'h7F);
        chk("reset_frame_tick", 32'(frame_tick), 32'd0);
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("first_digit_an_n", 32'(an_n), 32'h0E);

        // Frame length between consecutive ticks.
        wait_tick(cyc);
        wait_tick(cyc);
        chk("frame_len", 32'(cyc), 32'(FRAME_LIT));

        // Mid-frame write + commit, then a write that must be dropped.
        repeat (5) @(negedge clk);
        chk("ready_before_commit", 32'(wr_ready), 32'd1);
        wr_en = 1'b1; wr_idx = 2'd2; wr_seg = 7'h5B;
        @(negedge clk);
        wr_en = 1'b0; wr_commit = 1'b1;
        @(negedge clk);
        wr_commit = 1'b0;
        chk("ready_drop", 32'(wr_ready), 32'd0);
        wr_en = 1'b1; wr_idx = 2'd1; wr_seg = 7'h06;
        @(negedge clk);
        idle_inputs();
        wait_tick(cyc);
        chk("ready_rise", 32'(wr_ready), 32'd1);
        chk("tick_on_digit0", 32'(an_n), 32'h0E);
        wait_an(4'b1011);
        chk("digit2_committed", 32'(seg_n), 32'h24);

        wr_commit = 1'b1;
        @(negedge clk);
        wr_commit = 1'b0;
        wait_tick(cyc);
        wait_an(4'b1101);
        chk("dropped_write_idx1", 32'(seg_n), 32'h7F);

        // Write and commit in the same cycle.
        wr_en = 1'b1; wr_idx = 2'd0; wr_seg = 7'h3F; wr_commit = 1'b1;
        @(negedge clk);
        idle_inputs();
        wait_tick(cyc);
        chk("same_cycle_an_n", 32'(an_n), 32'h0E);
        chk("same_cycle_seg_n", 32'(seg_n), 32'h40);

        // Randomized traffic against the model.
        repeat (1500) begin
            @(negedge clk);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_idx    = 2'($urandom_range(0, 3));
            wr_seg    = 7'($urandom_range(0, 127));
            wr_commit = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        idle_inputs();

        // Asynchronous reset with a commit pending.
        begin
            int n = 0;
            while (wr_ready !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        wr_en = 1'b1; wr_idx = 2'd3; wr_seg = 7'h7F; wr_commit = 1'b1;
        @(negedge clk);
        idle_inputs();
        chk("pending_before_reset", 32'(wr_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_an_n", 32'(an_n), 32'h0E);
        chk("async_reset_seg_n", 32'(seg_n), 32'h7F);
        chk("async_reset_frame_tick", 32'(frame_tick), 32'd0);
        chk("async_reset_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(cyc);
        wait_an(4'b0111);
        chk("post_reset_digit3_blank", 32'(seg_n), 32'h7F);
        chk("post_reset_wr_ready", 32'(wr_ready), 32'd1);
        repeat (2 * FRAME) @(negedge clk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
